// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit for a 5-stage RV32 pipeline: opcode decode, load-use stall,
// branch flush and the ID/EX, EX/MEM, MEM/WB control registers.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            op_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  id_branch_o,
  output logic                  illegal_o,
  output logic                  illegal_sticky_o,
  output logic [ALUOP_W-1:0]    ex_alu_op_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_mem_read_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [REG_ADDR_W-1:0] mem_rd_addr_o,
  output logic                  wb_reg_write_o,
  output logic                  wb_mem_reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o
);

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic                  w_reg_write;
  logic                  w_mem_reg;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [ALUOP_W-1:0]    w_alu_op;
  logic                  w_alu_src;
  logic                  w_branch;
  logic                  w_illegal;
  logic                  w_rw_eff;
  logic                  w_hazard;
  logic                  w_stall;

  logic                  r_ex_reg_write;
  logic                  r_ex_mem_reg;
  logic                  r_ex_mem_read;
  logic                  r_ex_mem_write;
  logic [ALUOP_W-1:0]    r_ex_alu_op;
  logic                  r_ex_alu_src;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_mem_reg_write;
  logic                  r_mem_mem_reg;
  logic                  r_mem_mem_read;
  logic                  r_mem_mem_write;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_reg_write;
  logic                  r_wb_mem_reg;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_sticky;

  always_comb begin
    w_reg_write = 1'b0;
    w_mem_reg   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_op    = ALUOP_W'(0);
    w_alu_src   = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (op_i)
      OP_NOP: w_alu_op = ALUOP_W'(2);
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_W'(2);
      end
      OP_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_LD: begin
        w_reg_write = 1'b1;
        w_mem_reg   = 1'b1;
        w_mem_read  = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_ST: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        w_alu_op = ALUOP_W'(1);
        w_branch = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // x0 is hardwired zero, so a write to it is dropped and the rd field is not carried
  assign w_rw_eff = w_reg_write & (rd_addr_i != '0);
  assign w_hazard = r_ex_mem_read & (r_ex_rd != '0) &
                    ((r_ex_rd == rs1_addr_i) | (r_ex_rd == rs2_addr_i));
  assign w_stall  = (HAZARD_EN != 0) ? w_hazard : 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_reg    <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_alu_op     <= ALUOP_W'(0);
      r_ex_alu_src    <= 1'b0;
      r_ex_rd         <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_reg   <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_mem_mem_write <= 1'b0;
      r_mem_rd        <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_reg    <= 1'b0;
      r_wb_rd         <= '0;
      r_sticky        <= 1'b0;
    end else begin
      if (w_stall) begin
        r_ex_reg_write <= 1'b0;
        r_ex_mem_reg   <= 1'b0;
        r_ex_mem_read  <= 1'b0;
        r_ex_mem_write <= 1'b0;
        r_ex_alu_op    <= ALUOP_W'(0);
        r_ex_alu_src   <= 1'b0;
        r_ex_rd        <= '0;
      end else begin
        r_ex_reg_write <= w_rw_eff;
        r_ex_mem_reg   <= w_mem_reg;
        r_ex_mem_read  <= w_mem_read;
        r_ex_mem_write <= w_mem_write;
        r_ex_alu_op    <= w_alu_op;
        r_ex_alu_src   <= w_alu_src;
        r_ex_rd        <= w_rw_eff ? rd_addr_i : '0;
      end
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_mem_reg   <= r_ex_mem_reg;
      r_mem_mem_read  <= r_ex_mem_read;
      r_mem_mem_write <= r_ex_mem_write;
      r_mem_rd        <= r_ex_rd;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_mem_reg    <= r_mem_mem_reg;
      r_wb_rd         <= r_mem_rd;
      r_sticky        <= r_sticky | w_illegal;
    end
  end

  assign stall_o          = w_stall;
  assign pc_write_o       = ~w_stall;
  assign ifid_write_o     = ~w_stall;
  assign ifid_flush_o     = w_branch & branch_taken_i & ~w_stall;
  assign id_branch_o      = w_branch;
  assign illegal_o        = w_illegal;
  assign illegal_sticky_o = r_sticky;
  assign ex_alu_op_o      = r_ex_alu_op;
  assign ex_alu_src_o     = r_ex_alu_src;
  assign ex_mem_read_o    = r_ex_mem_read;
  assign ex_rd_addr_o     = r_ex_rd;
  assign mem_read_o       = r_mem_mem_read;
  assign mem_write_o      = r_mem_mem_write;
  assign mem_rd_addr_o    = r_mem_rd;
  assign wb_reg_write_o   = r_wb_reg_write;
  assign wb_mem_reg_o     = r_wb_mem_reg;
  assign wb_rd_addr_o     = r_wb_rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit; a second instance with hazard
// detection disabled shares the stimulus and must never stall.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       tk;
    logic       stall;
    logic       flush;
    logic       br;
    logic       ill;
    logic       stk;
    logic [1:0] ex_op;
    logic       ex_src;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic       m_rd;
    logic       m_wr;
    logic [4:0] m_rda;
    logic       w_rw;
    logic       w_mr;
    logic [4:0] w_rda;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = OP_R;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic [4:0] rd = 5'd5;
  logic       tk = 1'b0;

  logic       stall, pcw, ifw, flush, br, ill, stk, ex_src, ex_mr, m_rd, m_wr, w_rw, w_mr;
  logic [1:0] ex_op;
  logic [4:0] ex_rd, m_rda, w_rda;
  logic       n_stall, n_pcw, n_ifw, n_flush, n_br, n_ill, n_stk, n_ex_src, n_ex_mr;
  logic       n_m_rd, n_m_wr, n_w_rw, n_w_mr;
  logic [1:0] n_ex_op;
  logic [4:0] n_ex_rd, n_m_rda, n_w_rda;

  int   checks = 0;
  int   errors = 0;
  int   row = -1;
  vec_t vecs[17];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .HAZARD_EN(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rd_addr_i(rd), .branch_taken_i(tk), .stall_o(stall), .pc_write_o(pcw),
    .ifid_write_o(ifw), .ifid_flush_o(flush), .id_branch_o(br), .illegal_o(ill),
    .illegal_sticky_o(stk), .ex_alu_op_o(ex_op), .ex_alu_src_o(ex_src),
    .ex_mem_read_o(ex_mr), .ex_rd_addr_o(ex_rd), .mem_read_o(m_rd),
    .mem_write_o(m_wr), .mem_rd_addr_o(m_rda), .wb_reg_write_o(w_rw),
    .wb_mem_reg_o(w_mr), .wb_rd_addr_o(w_rda)
  );

  pipe_ctrl_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .HAZARD_EN(0)) u_dut_nh (
    .clk_i(clk), .rst_i(rst), .op_i(op), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rd_addr_i(rd), .branch_taken_i(tk), .stall_o(n_stall), .pc_write_o(n_pcw),
    .ifid_write_o(n_ifw), .ifid_flush_o(n_flush), .id_branch_o(n_br), .illegal_o(n_ill),
    .illegal_sticky_o(n_stk), .ex_alu_op_o(n_ex_op), .ex_alu_src_o(n_ex_src),
    .ex_mem_read_o(n_ex_mr), .ex_rd_addr_o(n_ex_rd), .mem_read_o(n_m_rd),
    .mem_write_o(n_m_wr), .mem_rd_addr_o(n_m_rda), .wb_reg_write_o(n_w_rw),
    .wb_mem_reg_o(n_w_mr), .wb_rd_addr_o(n_w_rda)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_ex_op"}, 32'(ex_op), 32'd0);
    chk({tag, "_ex_src"}, 32'(ex_src), 32'd0);
    chk({tag, "_ex_mr"}, 32'(ex_mr), 32'd0);
    chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, "_mem_rd"}, 32'(m_rd), 32'd0);
    chk({tag, "_mem_wr"}, 32'(m_wr), 32'd0);
    chk({tag, "_mem_rda"}, 32'(m_rda), 32'd0);
    chk({tag, "_wb_rw"}, 32'(w_rw), 32'd0);
    chk({tag, "_wb_mr"}, 32'(w_mr), 32'd0);
    chk({tag, "_wb_rda"}, 32'(w_rda), 32'd0);
    chk({tag, "_sticky"}, 32'(stk), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    // op, rs1, rs2, rd, tk | stall flush br ill stk | ex_op src mr rd | mem rd wr rda | wb rw mr rda
    vecs[0]  = '{OP_R,   5'd1,  5'd2, 5'd5,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0};
    vecs[1]  = '{OP_LD,  5'd1,  5'd2, 5'd6,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,5'd5,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0};
    vecs[2]  = '{OP_NOP, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b1,1'b1,5'd6,  1'b0,1'b0,5'd5,  1'b0,1'b0,5'd0};
    vecs[3]  = '{OP_NOP, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,5'd0,  1'b1,1'b0,5'd6,  1'b1,1'b0,5'd5};
    vecs[4]  = '{OP_LD,  5'd3,  5'd4, 5'd7,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b1,1'b1,5'd6};
    vecs[5]  = '{OP_R,   5'd7,  5'd1, 5'd8,  1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b1,1'b1,5'd7,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0};
    vecs[6]  = '{OP_R,   5'd7,  5'd1, 5'd8,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,5'd0,  1'b1,1'b0,5'd7,  1'b0,1'b0,5'd0};
    vecs[7]  = '{OP_LD,  5'd2,  5'd3, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,5'd8,  1'b0,1'b0,5'd0,  1'b1,1'b1,5'd7};
    vecs[8]  = '{OP_R,   5'd0,  5'd0, 5'd9,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b1,1'b1,5'd0,  1'b0,1'b0,5'd8,  1'b0,1'b0,5'd0};
    vecs[9]  = '{OP_BEQ, 5'd1,  5'd2, 5'd0,  1'b1, 1'b0,1'b1,1'b1,1'b0,1'b0, 2'b10,1'b0,1'b0,5'd9,  1'b1,1'b0,5'd0,  1'b1,1'b0,5'd8};
    vecs[10] = '{OP_ST,  5'd1,  5'd2, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,5'd0,  1'b0,1'b0,5'd9,  1'b0,1'b1,5'd0};
    vecs[11] = '{OP_BAD, 5'd1,  5'd2, 5'd3,  1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,1'b1,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b1,1'b0,5'd9};
    vecs[12] = '{OP_I,   5'd1,  5'd2, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,1'b0,1'b0,5'd0,  1'b0,1'b1,5'd0,  1'b0,1'b0,5'd0};
    vecs[13] = '{OP_LD,  5'd1,  5'd2, 5'd10, 1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,1'b1,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0};
    vecs[14] = '{OP_BEQ, 5'd10, 5'd0, 5'd0,  1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1, 2'b00,1'b1,1'b1,5'd10, 1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0};
    vecs[15] = '{OP_BEQ, 5'd10, 5'd0, 5'd0,  1'b1, 1'b0,1'b1,1'b1,1'b0,1'b1, 2'b00,1'b0,1'b0,5'd0,  1'b1,1'b0,5'd10, 1'b0,1'b0,5'd0};
    vecs[16] = '{OP_NOP, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01,1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b1,1'b1,5'd10};

    // Two reset edges with an R-type sitting in ID
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk_regs_zero("reset");
    chk("reset_illegal", 32'(ill), 32'd0);
    chk("reset_nh_stall", 32'(n_stall), 32'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      row = i;
      rst = 1'b1;
      op  = vecs[i].op;
      rs1 = vecs[i].rs1;
      rs2 = vecs[i].rs2;
      rd  = vecs[i].rd;
      tk  = vecs[i].tk;
      #2;
      chk("stall", 32'(stall), 32'(vecs[i].stall));
      chk("pc_write", 32'(pcw), 32'(!vecs[i].stall));
      chk("ifid_write", 32'(ifw), 32'(!vecs[i].stall));
      chk("flush", 32'(flush), 32'(vecs[i].flush));
      chk("id_branch", 32'(br), 32'(vecs[i].br));
      chk("illegal", 32'(ill), 32'(vecs[i].ill));
      chk("sticky", 32'(stk), 32'(vecs[i].stk));
      chk("ex_alu_op", 32'(ex_op), 32'(vecs[i].ex_op));
      chk("ex_alu_src", 32'(ex_src), 32'(vecs[i].ex_src));
      chk("ex_mem_read", 32'(ex_mr), 32'(vecs[i].ex_mr));
      chk("ex_rd", 32'(ex_rd), 32'(vecs[i].ex_rd));
      chk("mem_read", 32'(m_rd), 32'(vecs[i].m_rd));
      chk("mem_write", 32'(m_wr), 32'(vecs[i].m_wr));
      chk("mem_rd", 32'(m_rda), 32'(vecs[i].m_rda));
      chk("wb_reg_write", 32'(w_rw), 32'(vecs[i].w_rw));
      chk("wb_mem_reg", 32'(w_mr), 32'(vecs[i].w_mr));
      chk("wb_rd", 32'(w_rda), 32'(vecs[i].w_rda));
      chk("nh_stall", 32'(n_stall), 32'd0);
      chk("nh_pc_write", 32'(n_pcw), 32'd1);
    end

    // Without hazard detection the load-use pair at rows 4/5 flows straight through
    chk("nh_sticky", 32'(n_stk), 32'd1);

    // Mid-run reset discards in-flight ops and clears the sticky flag
    @(negedge clk);
    row = 100;
    rst = 1'b0;
    op  = OP_R;
    rd  = 5'd5;
    rs1 = 5'd10;
    rs2 = 5'd0;
    tk  = 1'b0;
    @(negedge clk);
    #2;
    chk_regs_zero("midreset");
    chk("midreset_nh_sticky", 32'(n_stk), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
